// File: rtl/cipher_job_arbiter_if.sv
// ---------------------------------------------------------------------------
// cipher_job_arbiter_if
//
// Bundles the requester-side job/response signals and the cipher-core
// Avalon-MM master signals of cipher_job_arbiter.
//
// Parameters:
//   NREQ - number of requesters (2..8)
//
// Modports:
//   slave  - the arbiter's view: takes jobs from requesters, drives the core
//   master - the environment's view: requesters plus the cipher core model
//
// Signals:
//   req_valid[NREQ]        job pending per requester
//   req_text[NREQ*128]     plaintext, requester i at [128*i+127:128*i]
//   req_key[NREQ*128]      key, same packing
//   req_ready[NREQ]        one-cycle one-hot pulse: job i latched
//   rsp_valid[NREQ]        one-cycle one-hot pulse: result for requester i
//   rsp_data[128]          result, valid only while rsp_valid is nonzero
//   rsp_err                qualifies rsp_valid: job aborted, rsp_data = 0
//   busy                   arbiter not idle
//   core_address           core slave address (1 only on the last load beat)
//   core_write/core_read   core strobes
//   core_writedata[32]     core write data
//   core_readdata[32]      core read data (latency 1)
//   core_waitrequest       core stall
// ---------------------------------------------------------------------------
interface cipher_job_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*128-1:0]   req_text;
    logic [NREQ*128-1:0]   req_key;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [127:0]          rsp_data;
    logic                  rsp_err;
    logic                  busy;
    logic                  core_address;
    logic                  core_write;
    logic                  core_read;
    logic [31:0]           core_writedata;
    logic [31:0]           core_readdata;
    logic                  core_waitrequest;

    modport slave (
        input  req_valid,
        input  req_text,
        input  req_key,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err,
        output busy,
        output core_address,
        output core_write,
        output core_read,
        output core_writedata,
        input  core_readdata,
        input  core_waitrequest
    );

    modport master (
        output req_valid,
        output req_text,
        output req_key,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err,
        input  busy,
        input  core_address,
        input  core_write,
        input  core_read,
        input  core_writedata,
        output core_readdata,
        output core_waitrequest
    );
endinterface

// File: rtl/cipher_job_arbiter.sv
// ---------------------------------------------------------------------------
// cipher_job_arbiter
//
// Shares one 128-bit block-cipher core (32-bit Avalon-MM slave: 8 load
// writes, compute, 4 result reads) between NREQ requesters. A round-robin
// pick chooses one pending job, its text/key are latched, the full core bus
// sequence is run, and the 128-bit result is returned to the granted
// requester. This block is the only master on the core's slave port.
//
// Optional feature (compile-time macro CIPHER_ARB_WDT_EN):
//   a watchdog counts stalled WAIT cycles; after WDT_CYCLES of them the job
//   is aborted through the ERR state (rsp_valid with rsp_err = 1, data 0).
//   Without the macro there is no counter, no ERR state, rsp_err is 0.
//
// Parameters:
//   NREQ       - number of requesters (2..8)
//   WDT_CYCLES - compute-phase watchdog limit in clk cycles
//
// Ports:
//   clk         - clock
//   reset       - synchronous, active-high
//   bus         - cipher_job_arbiter_if.slave (requester and core signals)
//   o_dbg_state - current FSM state encoding (S_* constants below)
//
// Handshake rules:
//   Requester side: req_valid[i] with its text/key is held by the requester
//   until the one-cycle req_ready[i] pulse; a requester may also withdraw
//   before that and is then simply not chosen. rsp_valid[i] is a one-cycle
//   pulse with no back-pressure; rsp_data/rsp_err are meaningful only then.
//   Core side: a beat transfers on a clk edge where the strobe is 1 and
//   core_waitrequest is 0; strobe, address and writedata hold until then.
//   Read data arrives one cycle after the accepting edge.
// ---------------------------------------------------------------------------
module cipher_job_arbiter #(
    parameter int NREQ       = 4,
    parameter int WDT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    cipher_job_arbiter_if.slave   bus,
    output logic [2:0]            o_dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_WR    = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RD    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    generate
        if (NREQ < 2 || NREQ > 8 || WDT_CYCLES < 1) begin : g_param_check
            $error("cipher_job_arbiter: NREQ must be 2..8 and WDT_CYCLES >= 1");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State and job registers
    // -----------------------------------------------------------------------
    logic [2:0]    r_state;
    logic [PW-1:0] r_ptr;        // last granted requester
    logic [PW-1:0] r_winner;     // requester owning the current job
    logic [255:0]  r_job;        // {key, text}: load beat b is r_job[32*b +: 32]
    logic [127:0]  r_result;
    logic [2:0]    r_beat;       // write beat 0..7, or reads accepted 1..4
    logic          r_cap_pend;   // a read was accepted last edge, data is on the bus now
    logic [1:0]    r_cap_idx;    // result word that the pending capture fills

`ifdef CIPHER_ARB_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] r_wdt;
`endif

    logic          w_accept_wr;
    logic          w_accept_rd;
    logic          w_any;
    logic [PW-1:0] w_winner;
    int            w_idx;
    int            w_sel;
    logic [NREQ-1:0] w_win_onehot;
    logic [NREQ-1:0] w_job_onehot;

    assign w_accept_wr = bus.core_write & ~bus.core_waitrequest;
    assign w_accept_rd = bus.core_read  & ~bus.core_waitrequest;
    assign o_dbg_state = r_state;

    // -----------------------------------------------------------------------
    // Round-robin pick: first set req_valid searching from r_ptr+1 upward
    // with wrap. Walking k downward lets the nearest candidate win last.
    // -----------------------------------------------------------------------
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (bus.req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = PW'(w_idx);
            end
        end
    end

    assign w_sel = int'(w_winner);

    always_comb begin
        w_win_onehot = '0;
        w_job_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_win_onehot[i] = (w_winner == PW'(i));
            w_job_onehot[i] = (r_winner == PW'(i));
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from the registered state so every output is 0 in
    // IDLE, including the cycle right after reset.
    // -----------------------------------------------------------------------
    always_comb begin
        bus.req_ready      = '0;
        bus.rsp_valid      = '0;
        bus.rsp_data       = '0;
        bus.busy           = (r_state != S_IDLE);
        bus.core_address   = 1'b0;
        bus.core_write     = 1'b0;
        bus.core_read      = 1'b0;
        bus.core_writedata = '0;

        case (r_state)
            S_GRANT: begin
                // A requester that withdrew between IDLE and GRANT is not
                // acknowledged; if nobody is left, no pulse is produced.
                if (w_any) begin
                    bus.req_ready = w_win_onehot;
                end
            end
            S_WR: begin
                bus.core_write     = 1'b1;
                bus.core_address   = (r_beat == 3'd7);
                bus.core_writedata = r_job[{r_beat, 5'b00000} +: 32];
            end
            S_WAIT: begin
                bus.core_read = 1'b1;
            end
            S_RD: begin
                // Reads stop once 4 are accepted; the last cycle in RD only
                // captures the final word.
                bus.core_read = (r_beat < 3'd4);
            end
            S_DONE: begin
                bus.rsp_valid = w_job_onehot;
                bus.rsp_data  = r_result;
            end
`ifdef CIPHER_ARB_WDT_EN
            S_ERR: begin
                bus.rsp_valid = w_job_onehot;
            end
`endif
            default: begin
            end
        endcase
    end

`ifdef CIPHER_ARB_WDT_EN
    assign bus.rsp_err = (r_state == S_ERR);
`else
    assign bus.rsp_err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM and datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= PW'(NREQ - 1);
            r_winner   <= '0;
            r_job      <= '0;
            r_result   <= '0;
            r_beat     <= '0;
            r_cap_pend <= 1'b0;
            r_cap_idx  <= '0;
`ifdef CIPHER_ARB_WDT_EN
            r_wdt      <= '0;
`endif
        end else begin
            // Read latency is 1: the word accepted on the previous edge is
            // on core_readdata during this cycle.
            r_cap_pend <= 1'b0;
            if (r_cap_pend) begin
                r_result[{r_cap_idx, 5'b00000} +: 32] <= bus.core_readdata;
            end

            case (r_state)
                S_IDLE: begin
                    if (|bus.req_valid) begin
                        r_state <= S_GRANT;
                    end
                end

                S_GRANT: begin
                    if (w_any) begin
                        r_winner <= w_winner;
                        r_ptr    <= w_winner;
                        r_job    <= {bus.req_key[w_sel*128 +: 128],
                                     bus.req_text[w_sel*128 +: 128]};
                        r_beat   <= '0;
                        r_state  <= S_WR;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end

                S_WR: begin
                    if (w_accept_wr) begin
                        if (r_beat == 3'd7) begin
                            r_beat  <= '0;
                            r_state <= S_WAIT;
                        end else begin
                            r_beat  <= r_beat + 3'd1;
                        end
                    end
                end

                S_WAIT: begin
                    if (w_accept_rd) begin
                        r_cap_pend <= 1'b1;
                        r_cap_idx  <= 2'd0;
                        r_beat     <= 3'd1;
                        r_state    <= S_RD;
`ifdef CIPHER_ARB_WDT_EN
                        r_wdt      <= '0;
                    end else if (r_wdt == WDT_W'(WDT_CYCLES - 1)) begin
                        // This is the WDT_CYCLES-th stalled cycle in WAIT.
                        r_wdt      <= '0;
                        r_state    <= S_ERR;
                    end else begin
                        r_wdt      <= r_wdt + 1'b1;
`endif
                    end
                end

                S_RD: begin
                    if (w_accept_rd) begin
                        r_cap_pend <= 1'b1;
                        r_cap_idx  <= r_beat[1:0];
                        r_beat     <= r_beat + 3'd1;
                    end
                    // Result word 3 is written this edge by the capture above.
                    if (r_cap_pend && r_cap_idx == 2'd3) begin
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

`ifdef CIPHER_ARB_WDT_EN
                S_ERR: begin
                    r_state <= S_IDLE;
                end
`endif

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cipher_job_arbiter.md
Name: cipher_job_arbiter

Overview:
Shares one 128-bit block-cipher core (32-bit Avalon-MM slave: 8 load writes, compute, 4 result reads) between NREQ requesters. Round-robin picks one pending job, latches its text/key, runs the full core bus sequence and returns the 128-bit result to the granted requester. Sits between the requester ports and the cipher core's slave port; it is the only master on that port.

Parameters:
NREQ, 4, number of requesters (2..8)
WDT_CYCLES, 1024, compute-phase watchdog limit in clk cycles (used only with CIPHER_ARB_WDT_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  NREQ  job pending per requester; held with data until req_ready
req_text  in  NREQ*128  plaintext, requester i at [128*i+127:128*i]
req_key  in  NREQ*128  key, same packing
req_ready  out  NREQ  one-cycle one-hot pulse: job i latched
rsp_valid  out  NREQ  one-cycle one-hot pulse: result for requester i
rsp_data  out  128  result; valid only while rsp_valid is nonzero
rsp_err  out  1  qualifies rsp_valid: job aborted, rsp_data = 0
busy  out  1  high in any state other than IDLE
core_address  out  1  core slave address
core_write  out  1  core write strobe
core_read  out  1  core read strobe
core_writedata  out  32  core write data
core_readdata  in  32  core read data
core_waitrequest  in  1  core stall

Behaviour:
- Reset: state IDLE; all outputs 0; rr pointer = NREQ-1, so requester 0 wins first; beat counter 0; watchdog 0. Reset mid-job drops the job silently: no rsp_valid; the requester's req_valid is not acknowledged again.
- Core bus: a beat is accepted on a clk edge where the strobe is 1 and core_waitrequest is 0. Strobes, address and writedata hold until acceptance.
- IDLE: if any req_valid is set, move to GRANT.
- GRANT (1 cycle): winner = first set req_valid searching from pointer+1 upward with wrap. Latch its text/key into job registers. Pulse req_ready[winner]. Pointer = winner. Go to WR with beat = 0.
- WR: core_write = 1. core_writedata for beats 0..7 = text[31:0], text[63:32], text[95:64], text[127:96], key[31:0], key[63:32], key[95:64], key[127:96]. core_address = 1 only on beat 7, else 0. After beat 7 is accepted, go to WAIT.
- WAIT: core_read = 1, core_address = 0. Stays while core_waitrequest = 1 (core computing, 12 rounds). First accepted read is result beat 0; go to RD with beat = 1.
- RD: core_read = 1 until 4 beats are accepted in total. Read latency is 1: core_readdata is captured on the edge after each acceptance into result[32*b+31:32*b], b = 0..3. After the 4th capture, go to DONE.
- DONE (1 cycle): rsp_valid[winner] = 1, rsp_data = result, rsp_err = 0. Go to IDLE; a new GRANT can occur 2 cycles after DONE.
- Requests that arrive or drop while busy are ignored until the next IDLE. A requester dropping req_valid before req_ready is allowed and is simply not chosen.
- Minimum latency from req_ready to rsp_valid, with no stalls: 8 WR + 1 WAIT + 3 RD + 1 capture + DONE = 14 cycles.

Optional Feature:
CIPHER_ARB_WDT_EN:
- When defined, a counter runs in WAIT. If it reaches WDT_CYCLES with waitrequest still 1, go to ERR.
- ERR (1 cycle): rsp_valid[winner] = 1, rsp_err = 1, rsp_data = 0, all core strobes 0, then IDLE.
- When undefined, there is no counter and no ERR state. WAIT waits indefinitely and rsp_err is tied to 0.

Test Plan:
- Only req 0, text = 0, key = 0, core model never stalls -> req_ready = 0001; writes show 8 beats with address = 1 on beat 8 only; rsp_valid = 0001 exactly 14 cycles later; rsp_data equals the cipher golden model.
- req 1 and req 2 asserted together right after reset -> req 1 served first, then req 2; each gets its own result.
- All 4 requesting continuously for 8 jobs -> grant order 0,1,2,3,0,1,2,3; no requester is starved.
- Core holds waitrequest for 3 cycles on write beat 4 and for 20 cycles in WAIT -> strobes and data hold stable; result is unchanged; latency grows by 23.
- reset asserted on write beat 5 -> next cycle all outputs 0 and state IDLE; no rsp_valid; next grant goes to requester 0.
- With CIPHER_ARB_WDT_EN and WDT_CYCLES = 16, core never drops waitrequest -> rsp_valid with rsp_err = 1 and rsp_data = 0 after 16 WAIT cycles, then back to IDLE.
